// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Sequencing and hazard controller for a 5-stage MIPS pipeline.
//             Load-use stall, taken-branch flush, run/drain/halt sequencing
//             and saturating stall/flush event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_halt_req,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_memRead,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_mem_branch,
    input  logic             i_mem_zf,
    output logic             o_pc_write,
    output logic             o_pc_src,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_flush,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    // Sequencer states; the encoding is visible on o_state.
    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_RUN    = 2'b01;
    localparam logic [1:0] c_ST_DRAIN  = 2'b10;
    localparam logic [1:0] c_ST_HALTED = 2'b11;

    // Drain counter must hold DRAIN_CYCLES itself.
    localparam int              c_DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_DW-1:0] c_DRAIN_LOAD = c_DW'(DRAIN_CYCLES);
    localparam logic [c_DW-1:0] c_DRAIN_ONE  = c_DW'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [c_DW-1:0]  r_drain;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0]       w_next_state;
    logic [c_DW-1:0]  w_next_drain;
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic             w_lu;
    logic             w_brt;

    // Load-use: the load in EX writes a register the ID instruction reads.
    // Register 0 is never a real dependency.
    assign w_lu  = i_ex_memRead && (i_ex_rt != '0) &&
                   ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    assign w_brt = i_mem_branch && i_mem_zf;

    assign o_state     = r_state;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // Mealy pipeline controls and next-state selection.
    always_comb begin
        // Quiescent pipeline: nothing advances, every stage is forced empty.
        o_pc_write     = 1'b0;
        o_pc_src       = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
        o_ex_mem_flush = 1'b1;
        w_next_state   = r_state;
        w_next_drain   = r_drain;
        w_stall_evt    = 1'b0;
        w_flush_evt    = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_HALTED: begin
                if (i_run) begin
                    w_next_state = c_ST_RUN;
                end
            end

            c_ST_RUN: begin
                o_pc_write     = 1'b1;
                o_if_id_write  = 1'b1;
                o_if_id_flush  = 1'b0;
                o_id_ex_bubble = 1'b0;
                o_ex_mem_flush = 1'b0;
                if (w_brt) begin
                    // Younger stages are on the wrong path, so any load-use
                    // they show is irrelevant.
                    o_pc_src       = 1'b1;
                    o_if_id_flush  = 1'b1;
                    o_id_ex_bubble = 1'b1;
                    o_ex_mem_flush = 1'b1;
                    w_flush_evt    = 1'b1;
                end else if (w_lu) begin
                    // One bubble suffices: next cycle EX no longer holds the load.
                    o_pc_write     = 1'b0;
                    o_if_id_write  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                    w_stall_evt    = 1'b1;
                end
                if (i_halt_req) begin
                    w_next_state = c_ST_DRAIN;
                    w_next_drain = c_DRAIN_LOAD;
                end
            end

            c_ST_DRAIN: begin
                // Fetch stops; NOPs are fed behind the in-flight instructions.
                o_pc_write     = 1'b0;
                o_if_id_write  = 1'b1;
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b0;
                o_ex_mem_flush = 1'b0;
                if (w_brt) begin
                    // Redirect the PC so a later resume fetches the target.
                    o_pc_src       = 1'b1;
                    o_pc_write     = 1'b1;
                    o_id_ex_bubble = 1'b1;
                    o_ex_mem_flush = 1'b1;
                    w_flush_evt    = 1'b1;
                end else if (w_lu) begin
                    // The dependent instruction waits in IF/ID; this cycle
                    // retires nothing, so the drain count is not consumed.
                    o_if_id_write  = 1'b0;
                    o_if_id_flush  = 1'b0;
                    o_id_ex_bubble = 1'b1;
                    w_stall_evt    = 1'b1;
                end
                if (w_brt || !w_lu) begin
                    if (r_drain <= c_DRAIN_ONE) begin
                        w_next_state = c_ST_HALTED;
                        w_next_drain = '0;
                    end else begin
                        w_next_drain = r_drain - c_DRAIN_ONE;
                    end
                end
            end

            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase

        // Reset holds the pipeline quiescent regardless of the current state.
        if (reset) begin
            o_pc_write     = 1'b0;
            o_pc_src       = 1'b0;
            o_if_id_write  = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
            o_ex_mem_flush = 1'b1;
        end
    end

    // State, drain counter and saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_drain     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_drain <= w_next_drain;
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Self-checking bench for pipeline_hazard_ctrl: directed vector
//             table, drain/halt/reset sequences, randomized traffic against a
//             behavioural model, and counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int REG_W        = 5;
    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // Model modes, numbered to match the o_state encoding.
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_run, i_halt_req;
    logic [REG_W-1:0] i_id_rs, i_id_rt, i_ex_rt;
    logic             i_id_uses_rt, i_ex_memRead, i_mem_branch, i_mem_zf;
    logic             o_pc_write, o_pc_src, o_if_id_write, o_if_id_flush;
    logic             o_id_ex_bubble, o_ex_mem_flush;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_W(REG_W), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_halt_req(i_halt_req),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_uses_rt(i_id_uses_rt),
        .i_ex_memRead(i_ex_memRead), .i_ex_rt(i_ex_rt),
        .i_mem_branch(i_mem_branch), .i_mem_zf(i_mem_zf),
        .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
        .o_if_id_write(o_if_id_write), .o_if_id_flush(o_if_id_flush),
        .o_id_ex_bubble(o_id_ex_bubble), .o_ex_mem_flush(o_ex_mem_flush),
        .o_state(o_state), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode, remaining bubbles to retire, event totals.
    int m_mode = M_IDLE;
    int m_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        bit         mem_read;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        bit         uses_rt;
        bit         branch;
        bit         zf;
        logic [5:0] exp_outs;   // {pc_write,pc_src,if_id_write,if_id_flush,id_ex_bubble,ex_mem_flush}
        int         stall_inc;
        int         flush_inc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                          input logic [4:0] rt, input bit ur, input bit br, input bit zf);
        i_ex_memRead = mr; i_ex_rt = ert; i_id_rs = rs; i_id_rt = rt;
        i_id_uses_rt = ur; i_mem_branch = br; i_mem_zf = zf;
    endtask

    function automatic bit model_lu();
        return i_ex_memRead && (i_ex_rt != 0) &&
               ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    endfunction

    function automatic logic [5:0] model_outs();
        bit lu, brt;
        lu  = model_lu();
        brt = i_mem_branch && i_mem_zf;
        if (reset || m_mode == M_IDLE || m_mode == M_HALTED) return 6'b000111;
        if (brt) return 6'b111111;
        if (lu)  return 6'b000010;
        return (m_mode == M_RUN) ? 6'b101000 : 6'b001100;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        bit lu, brt;
        lu  = model_lu();
        brt = i_mem_branch && i_mem_zf;
        if (reset) begin
            m_mode = M_IDLE; m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_HALTED: if (i_run) m_mode = M_RUN;
                M_RUN: begin
                    if (brt) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
                    else if (lu) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
                    if (i_halt_req) begin m_mode = M_DRAIN; m_left = DRAIN_CYCLES; end
                end
                default: begin
                    if (brt) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
                    else if (lu) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
                    if (brt || !lu) begin
                        m_left--;
                        if (m_left == 0) m_mode = M_HALTED;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [5:0] act;
        act = {o_pc_write, o_pc_src, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_ex_mem_flush};
        chk({tag, "/outs"},  {26'd0, act}, {26'd0, model_outs()});
        chk({tag, "/state"}, {30'd0, o_state}, m_mode);
        chk({tag, "/stall"}, {16'd0, o_stall_cnt}, m_stall);
        chk({tag, "/flush"}, {16'd0, o_flush_cnt}, m_flush);
    endtask

    // Called at posedge+1: check at negedge, step the model, cross the edge.
    task automatic run_cycle(input bit do_check, input string tag);
        @(negedge clk);
        if (do_check) check_all(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_run();
        i_run = 1'b1;
        run_cycle(1, "start");
        i_run = 1'b0;
    endtask

    initial begin
        int n;
        int exp_stall, exp_flush;

        vecs[0] = '{1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 6'b000010, 1, 0}; // lu on rs
        vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 6'b101000, 0, 0}; // $0 load
        vecs[2] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 6'b101000, 0, 0}; // rt not read
        vecs[3] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 6'b000010, 1, 0}; // lu on rt
        vecs[4] = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 6'b101000, 0, 0}; // not a load
        vecs[5] = '{1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 6'b111111, 0, 1}; // brt over lu
        vecs[6] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 6'b101000, 0, 0}; // not taken
        vecs[7] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 6'b101000, 0, 0}; // zf alone
        vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 6'b111111, 0, 1}; // brt alone

        reset = 1'b1; i_run = 1'b0; i_halt_req = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset for two cycles, then start.
        run_cycle(1, "reset");
        run_cycle(1, "reset");
        reset = 1'b0;
        go_run();
        chk("run_state", {30'd0, o_state}, 32'd1);
        @(negedge clk);
        chk("run_pc_write", {31'd0, o_pc_write}, 32'd1);
        @(posedge clk); #1;
        model_step();

        // Directed hazard table in RUN.
        exp_stall = 0; exp_flush = 0;
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].mem_read, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
                   vecs[i].uses_rt, vecs[i].branch, vecs[i].zf);
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i),
                {26'd0, o_pc_write, o_pc_src, o_if_id_write, o_if_id_flush, o_id_ex_bubble, o_ex_mem_flush},
                {26'd0, vecs[i].exp_outs});
            model_step();
            @(posedge clk); #1;
            exp_stall += vecs[i].stall_inc;
            exp_flush += vecs[i].flush_inc;
            chk($sformatf("vec%0d_stall", i), {16'd0, o_stall_cnt}, exp_stall);
            chk($sformatf("vec%0d_flush", i), {16'd0, o_flush_cnt}, exp_flush);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);

        // Halt with a clean drain: four DRAIN cycles, then HALTED.
        i_halt_req = 1'b1;
        run_cycle(1, "halt");
        i_halt_req = 1'b0;
        n = 0;
        while (o_state == 2'b10 && n < 20) begin
            n++;
            @(negedge clk);
            chk("drain_pc_write", {31'd0, o_pc_write}, 32'd0);
            @(posedge clk); #1;
            model_step();
        end
        chk("drain_len", n, DRAIN_CYCLES);
        chk("halted_state", {30'd0, o_state}, 32'd3);
        go_run();
        chk("resume_state", {30'd0, o_state}, 32'd1);

        // Halt with one load-use inside the drain: one extra cycle.
        i_halt_req = 1'b1;
        run_cycle(1, "halt2");
        i_halt_req = 1'b0;
        n = 0;
        while (o_state == 2'b10 && n < 20) begin
            n++;
            if (n == 2) set_in(1, 8, 8, 0, 0, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0);
            run_cycle(1, "drain_lu");
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("drain_lu_len", n, DRAIN_CYCLES + 1);
        chk("halted2_state", {30'd0, o_state}, 32'd3);
        go_run();

        // Reset landing in the second DRAIN cycle.
        i_halt_req = 1'b1;
        run_cycle(1, "halt3");
        i_halt_req = 1'b0;
        run_cycle(1, "drain1");
        reset = 1'b1;
        run_cycle(1, "drain2_reset");
        reset = 1'b0;
        chk("mid_reset_state", {30'd0, o_state}, 32'd0);
        chk("mid_reset_stall", {16'd0, o_stall_cnt}, 32'd0);
        chk("mid_reset_flush", {16'd0, o_flush_cnt}, 32'd0);
        @(negedge clk);
        chk("mid_reset_pc_write", {31'd0, o_pc_write}, 32'd0);
        @(posedge clk); #1;
        model_step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            i_run        = ($urandom_range(0, 9) == 0);
            i_halt_req   = ($urandom_range(0, 19) == 0);
            i_ex_memRead = $urandom_range(0, 1);
            i_ex_rt      = 5'($urandom_range(0, 3));
            i_id_rs      = 5'($urandom_range(0, 3));
            i_id_rt      = 5'($urandom_range(0, 3));
            i_id_uses_rt = $urandom_range(0, 1);
            i_mem_branch = ($urandom_range(0, 3) == 0);
            i_mem_zf     = $urandom_range(0, 1);
            run_cycle(1, "rand");
        end
        reset = 1'b0; i_run = 1'b0; i_halt_req = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);

        // Stall counter saturation.
        reset = 1'b1;
        run_cycle(0, "sat_reset");
        reset = 1'b0;
        go_run();
        set_in(1, 8, 8, 0, 0, 0, 0);
        for (int c = 0; c < CNT_MAX; c++) begin
            @(posedge clk); #1;
            model_step();
        end
        chk("sat_reach", {16'd0, o_stall_cnt}, 32'h0000FFFF);
        run_cycle(1, "sat_hold");
        chk("sat_hold_cnt", {16'd0, o_stall_cnt}, 32'h0000FFFF);
        set_in(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
